// File: rtl/sr_flag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sr_flag_ctrl
//  Brief    : Round-robin arbitrated set/reset flag bank. Each accepted request
//             runs IDLE -> APPLY -> DONE. SR_FLAG_TOGGLE_EN turns cmd 11 into
//             a toggle instead of an error.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_flag_ctrl #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req,
    input  logic [2*NREQ-1:0]             cmd,
    input  logic [NREQ*$clog2(NFLAG)-1:0] idx,
    output logic [NREQ-1:0]               gnt,
    output logic                          ack,
    output logic                          err,
    output logic                          busy,
    output logic [NFLAG-1:0]              flags
);

    localparam int              c_iw   = $clog2(NFLAG);
    localparam int              c_pw   = $clog2(NREQ);
    localparam logic [c_pw-1:0] c_last = c_pw'(NREQ - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_apply = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    logic [1:0]       r_state;
    logic [c_pw-1:0]  r_ptr;
    logic [c_pw-1:0]  r_win;
    logic [1:0]       r_cmd;
    logic [c_iw-1:0]  r_idx;
    logic [NREQ-1:0]  r_gnt;
    logic             r_ack;
    logic             r_err;
    logic             r_busy;
    logic [NFLAG-1:0] r_flags;

    logic [c_pw-1:0]  w_win;
    logic [c_pw-1:0]  w_cand;
    logic [1:0]       w_cmd;
    logic [c_iw-1:0]  w_idx;
    int               w_sum;

    // Scan from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        w_win  = r_ptr;
        w_cand = r_ptr;
        w_sum  = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_cand = c_pw'(w_sum);
            if (req[w_cand]) begin
                w_win = w_cand;
            end
        end
    end

    always_comb begin
        w_cmd = 2'b00;
        w_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == c_pw'(i)) begin
                w_cmd = cmd[2*i +: 2];
                w_idx = idx[c_iw*i +: c_iw];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_ptr   <= '0;
            r_win   <= '0;
            r_cmd   <= 2'b00;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_flags <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    if (|req) begin
                        r_state <= c_apply;
                        r_win   <= w_win;
                        r_cmd   <= w_cmd;
                        r_idx   <= w_idx;
                        r_gnt   <= NREQ'(1) << w_win;
                        r_busy  <= 1'b1;
                    end else begin
                        r_gnt  <= '0;
                        r_busy <= 1'b0;
                    end
                end
                c_apply: begin
                    case (r_cmd)
                        2'b01: r_flags[r_idx] <= 1'b0;
                        2'b10: r_flags[r_idx] <= 1'b1;
                        2'b11: begin
`ifdef SR_FLAG_TOGGLE_EN
                            r_flags[r_idx] <= ~r_flags[r_idx];
`endif
                        end
                        default: ;
                    endcase
`ifdef SR_FLAG_TOGGLE_EN
                    r_err <= 1'b0;
`else
                    r_err <= (r_cmd == 2'b11);
`endif
                    r_ack   <= 1'b1;
                    r_state <= c_done;
                end
                c_done: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_win == c_last) ? '0 : r_win + 1'b1;
                    r_state <= c_idle;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign err   = r_err;
    assign busy  = r_busy;
    assign flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_flag_ctrl
//  Brief    : Directed and randomized transaction-level bench for sr_flag_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_flag_ctrl;

    localparam int NREQ  = 4;
    localparam int NFLAG = 4;
    localparam int IW    = 2;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req   = '0;
    logic [2*NREQ-1:0]    cmd   = '0;
    logic [NREQ*IW-1:0]   idx   = '0;
    logic [NREQ-1:0]      gnt;
    logic                 ack;
    logic                 err;
    logic                 busy;
    logic [NFLAG-1:0]     flags;

    int checks   = 0;
    int failures = 0;

    // Reference state: flag bank contents and the round-robin start point.
    logic [NFLAG-1:0] m_flags = '0;
    int               m_ptr   = 0;

    sr_flag_ctrl #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .cmd   (cmd),
        .idx   (idx),
        .gnt   (gnt),
        .ack   (ack),
        .err   (err),
        .busy  (busy),
        .flags (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        logic [NREQ-1:0] sh;
        for (int k = 0; k < NREQ; k++) begin
            sh = r >> ((p + k) % NREQ);
            if (sh[0]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [2*NREQ-1:0] cmd_at(input int i, input logic [1:0] v);
        return (2*NREQ)'(v) << (2*i);
    endfunction

    function automatic logic [NREQ*IW-1:0] idx_at(input int i, input logic [IW-1:0] v);
        return (NREQ*IW)'(v) << (IW*i);
    endfunction

    // One full transaction: present inputs, follow APPLY/DONE/IDLE, compare against the model.
    task automatic do_op(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] c,
                         input logic [NREQ*IW-1:0] x, input bit mutate);
        int              w;
        logic [1:0]      lc;
        logic [IW-1:0]   li;
        logic [NREQ-1:0] g;
        logic            e_err;
        req = r;
        cmd = c;
        idx = x;
        w   = pick(r, m_ptr);
        @(posedge clk);
        @(negedge clk);
        if (w < 0) begin
            check("noreq_gnt",  gnt,  0);
            check("noreq_ack",  ack,  0);
            check("noreq_busy", busy, 0);
            check("noreq_err",  err,  0);
            return;
        end
        lc = 2'(c >> (2*w));
        li = IW'(x >> (IW*w));
        g  = NREQ'(1) << w;
        check("apply_gnt",   gnt,   g);
        check("apply_ack",   ack,   0);
        check("apply_busy",  busy,  1);
        check("apply_flags", flags, m_flags);
        if (mutate) begin
            req = NREQ'($urandom);
            cmd = (2*NREQ)'($urandom);
            idx = (NREQ*IW)'($urandom);
        end
        @(posedge clk);
        @(negedge clk);
        case (lc)
            2'b01: m_flags[li] = 1'b0;
            2'b10: m_flags[li] = 1'b1;
            2'b11: begin
`ifdef SR_FLAG_TOGGLE_EN
                m_flags[li] = ~m_flags[li];
`endif
            end
            default: ;
        endcase
`ifdef SR_FLAG_TOGGLE_EN
        e_err = 1'b0;
`else
        e_err = (lc == 2'b11);
`endif
        check("done_flags", flags, m_flags);
        check("done_ack",   ack,   1);
        check("done_err",   err,   e_err);
        check("done_gnt",   gnt,   g);
        check("done_busy",  busy,  1);
        @(posedge clk);
        @(negedge clk);
        m_ptr = (w + 1) % NREQ;
        check("idle_gnt",   gnt,   0);
        check("idle_ack",   ack,   0);
        check("idle_err",   err,   0);
        check("idle_busy",  busy,  0);
        check("idle_flags", flags, m_flags);
    endtask

    initial begin
        int w;
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",   gnt,   0);
        check("rst_ack",   ack,   0);
        check("rst_err",   err,   0);
        check("rst_busy",  busy,  0);
        check("rst_flags", flags, 0);
        rst_n = 1'b1;

        // Single set of flag 2 by requester 0
        do_op(4'b0001, cmd_at(0, 2'b10), idx_at(0, 2'd2), 1'b0);
        check("single_flags", flags, 4'b0100);

        // All requesters held: grants rotate, one per three cycles, no flag change
        for (int n = 0; n < 5; n++) begin
            do_op(4'b1111, '0, '0, 1'b0);
        end
        check("rr_flags", flags, 4'b0100);

        // Illegal / toggle command on flag 2
        do_op(4'b0100, cmd_at(2, 2'b11), idx_at(2, 2'd2), 1'b0);
`ifdef SR_FLAG_TOGGLE_EN
        check("cmd11_flags", flags, 4'b0000);
`else
        check("cmd11_flags", flags, 4'b0100);
`endif

        // No-op, then clear flag 2 after setting flags 0 and 3
        do_op(4'b1000, cmd_at(3, 2'b00), idx_at(3, 2'd1), 1'b0);
        do_op(4'b0010, cmd_at(1, 2'b10), idx_at(1, 2'd2), 1'b0);
        do_op(4'b0001, cmd_at(0, 2'b10), idx_at(0, 2'd0), 1'b0);
        do_op(4'b0100, cmd_at(2, 2'b10), idx_at(2, 2'd3), 1'b0);
        do_op(4'b1000, cmd_at(3, 2'b01), idx_at(3, 2'd2), 1'b0);
        check("clear_flags", flags, 4'b1001);

        // Granted requester changes its inputs mid-operation
        do_op(4'b0010, cmd_at(1, 2'b10), idx_at(1, 2'd1), 1'b1);
        check("mutate_flags", flags, 4'b1011);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            do_op(NREQ'($urandom_range(0, 15)), (2*NREQ)'($urandom),
                  (NREQ*IW)'($urandom), 1'($urandom_range(0, 1)));
        end

        // Ensure a nonzero bank and a nonzero pointer before the abort
        do_op(4'b0100, cmd_at(2, 2'b10), idx_at(2, 2'd0), 1'b0);

        // Reset asserted during APPLY of a set on flag 1
        req = 4'b0010;
        cmd = cmd_at(1, 2'b10);
        idx = idx_at(1, 2'd1);
        w   = pick(req, m_ptr);
        @(posedge clk);
        @(negedge clk);
        check("abort_apply_gnt", gnt, 4'b0010);
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk);
        @(negedge clk);
        check("abort_flags", flags, 0);
        check("abort_gnt",   gnt,   0);
        check("abort_ack",   ack,   0);
        check("abort_err",   err,   0);
        check("abort_busy",  busy,  0);
        m_flags = '0;
        m_ptr   = 0;
        rst_n   = 1'b1;

        // Pointer restarted at requester 0
        do_op(4'b1111, cmd_at(0, 2'b10), idx_at(0, 2'd3), 1'b0);
        check("post_abort_flags", flags, 4'b1000);

        // Quiet interface stays idle
        do_op(4'b0000, '0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
